// File: rtl/bypass_net_pkg.sv
// rtl/bypass_net_pkg.sv - shared widths and constants for the operand bypass network
package bypass_net_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int REG_IDX_W    = 5;
    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

endpackage

// File: rtl/bypass_src.sv
// rtl/bypass_src.sv - one source operand: stage match, youngest-wins priority, sticky hold register
module bypass_src
    import bypass_net_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_FWD = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_en,
    input  logic [REG_IDX_W-1:0]           src_addr,
    input  logic [XLEN-1:0]                src_rf,
    input  logic [NUM_FWD-1:0]             fwd_rd_en,
    input  logic [NUM_FWD*REG_IDX_W-1:0]   fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]        fwd_data,
    input  logic [NUM_FWD-1:0]             fwd_data_ok,
    input  logic                           capture_en,
    input  logic                           hold_clr,
    output logic [XLEN-1:0]                src_out,
    output logic                           src_ok
);

    logic            hold_flag_q, hold_flag_d;
    logic [XLEN-1:0] hold_val_q, hold_val_d;
    logic            hit;
    logic            win_ok;
    logic [XLEN-1:0] win_data;

    // Scan oldest to youngest so the youngest matching stage overwrites the rest.
    always_comb begin
        hit      = 1'b0;
        win_ok   = 1'b0;
        win_data = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (src_en && (src_addr != X0_IDX) && fwd_rd_en[k] &&
                (fwd_rd[k*REG_IDX_W +: REG_IDX_W] == src_addr)) begin
                hit      = 1'b1;
                win_ok   = fwd_data_ok[k];
                win_data = fwd_data[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        src_out = src_rf;
        src_ok  = 1'b1;
        if (hold_flag_q) begin
            src_out = hold_val_q;
        end else if (hit) begin
            src_out = win_data;
            src_ok  = win_ok;
        end
    end

    // Only forwarded values are captured; register-file operands stay live in the ID/EXE latch.
    always_comb begin
        hold_flag_d = hold_flag_q;
        hold_val_d  = hold_val_q;
        if (hold_clr) begin
            hold_flag_d = 1'b0;
            hold_val_d  = '0;
        end else if (capture_en && !hold_flag_q && hit && win_ok) begin
            hold_flag_d = 1'b1;
            hold_val_d  = win_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_flag_q <= 1'b0;
            hold_val_q  <= '0;
        end else begin
            hold_flag_q <= hold_flag_d;
            hold_val_q  <= hold_val_d;
        end
    end

endmodule

// File: rtl/bypass_net.sv
// rtl/bypass_net.sv - EXE operand bypass network with per-source hold and hazard stall counter
module bypass_net
    import bypass_net_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_SRC = 3,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           exe_valid,
    input  logic                           exe_ready,
    input  logic                           exe_flush,
    input  logic [NUM_SRC-1:0]             src_en,
    input  logic [NUM_SRC*REG_IDX_W-1:0]   src_addr,
    input  logic [NUM_SRC*XLEN-1:0]        src_rf,
    input  logic [NUM_FWD-1:0]             fwd_rd_en,
    input  logic [NUM_FWD*REG_IDX_W-1:0]   fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0]        fwd_data,
    input  logic [NUM_FWD-1:0]             fwd_data_ok,
    output logic [NUM_SRC*XLEN-1:0]        src_out,
    output logic [NUM_SRC-1:0]             src_ok,
    output logic                           operands_valid,
    output logic [CNT_W-1:0]               stall_cnt
);

    logic             capture_en;
    logic             hold_clr;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Holding only makes sense while the instruction is stuck in EXE.
    assign capture_en = exe_valid && !exe_ready && !exe_flush;
    assign hold_clr   = exe_ready || exe_flush;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        bypass_src #(
            .XLEN    (XLEN),
            .NUM_FWD (NUM_FWD)
        ) u_src (
            .clk         (clk),
            .rst         (rst),
            .src_en      (src_en[i]),
            .src_addr    (src_addr[i*REG_IDX_W +: REG_IDX_W]),
            .src_rf      (src_rf[i*XLEN +: XLEN]),
            .fwd_rd_en   (fwd_rd_en),
            .fwd_rd      (fwd_rd),
            .fwd_data    (fwd_data),
            .fwd_data_ok (fwd_data_ok),
            .capture_en  (capture_en),
            .hold_clr    (hold_clr),
            .src_out     (src_out[i*XLEN +: XLEN]),
            .src_ok      (src_ok[i])
        );
    end

    assign operands_valid = &src_ok;
    assign stall_cnt      = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (exe_valid && !exe_flush && !operands_valid && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_bypass_net.sv
// tb/tb_bypass_net.sv - directed bench with an operand-resolution model for bypass_net
module tb_bypass_net;

    localparam int XLEN = 64;
    localparam int NS   = 3;
    localparam int NF   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, exe_valid, exe_ready, exe_flush;
    logic [NS-1:0]     src_en;
    logic [NS*5-1:0]   src_addr;
    logic [NS*XLEN-1:0] src_rf;
    logic [NF-1:0]     fwd_rd_en, fwd_data_ok;
    logic [NF*5-1:0]   fwd_rd;
    logic [NF*XLEN-1:0] fwd_data;
    logic [NS*XLEN-1:0] src_out, src_out_s;
    logic [NS-1:0]     src_ok, src_ok_s;
    logic              operands_valid, ov_s;
    logic [31:0]       stall_cnt;
    logic [3:0]        stall_cnt_s;

    bypass_net #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD(NF), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_flush(exe_flush),
        .src_en(src_en), .src_addr(src_addr), .src_rf(src_rf),
        .fwd_rd_en(fwd_rd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
        .src_out(src_out), .src_ok(src_ok), .operands_valid(operands_valid), .stall_cnt(stall_cnt)
    );

    bypass_net #(.XLEN(XLEN), .NUM_SRC(NS), .NUM_FWD(NF), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_flush(exe_flush),
        .src_en(src_en), .src_addr(src_addr), .src_rf(src_rf),
        .fwd_rd_en(fwd_rd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
        .src_out(src_out_s), .src_ok(src_ok_s), .operands_valid(ov_s), .stall_cnt(stall_cnt_s)
    );

    int checks = 0;
    int errors = 0;

    bit              m_hf [NS];
    logic [63:0]     m_hv [NS];
    longint unsigned m_cnt;
    int              m_cnt4;

    logic [63:0] e_out [NS];
    bit          e_ok  [NS];
    bit          e_win [NS];
    bit          e_ov;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    // First matching stage in age order supplies the operand; held sources ignore the network.
    task automatic model_eval();
        logic [4:0] a;
        e_ov = 1'b1;
        for (int i = 0; i < NS; i++) begin
            a = src_addr[i*5 +: 5];
            e_win[i] = 1'b0;
            e_out[i] = src_rf[i*XLEN +: XLEN];
            e_ok[i]  = 1'b1;
            if (m_hf[i]) begin
                e_out[i] = m_hv[i];
            end else if (src_en[i] && a != 5'd0) begin
                for (int k = 0; k < NF; k++) begin
                    if (!e_win[i] && fwd_rd_en[k] && fwd_rd[k*5 +: 5] == a) begin
                        e_win[i] = 1'b1;
                        e_out[i] = fwd_data[k*XLEN +: XLEN];
                        e_ok[i]  = fwd_data_ok[k];
                    end
                end
            end
            e_ov = e_ov && e_ok[i];
        end
    endtask

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < NS; i++) begin m_hf[i] = 1'b0; m_hv[i] = '0; end
            m_cnt = 0; m_cnt4 = 0;
        end else begin
            model_eval();
            if (exe_valid && !exe_flush && !e_ov) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (exe_ready || exe_flush) begin
                for (int i = 0; i < NS; i++) begin m_hf[i] = 1'b0; m_hv[i] = '0; end
            end else if (exe_valid) begin
                for (int i = 0; i < NS; i++)
                    if (!m_hf[i] && e_win[i] && e_ok[i]) begin m_hf[i] = 1'b1; m_hv[i] = e_out[i]; end
            end
        end
    endtask

    task automatic compare_model();
        model_eval();
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("src_out%0d", i), src_out[i*XLEN +: XLEN], e_out[i]);
            chk($sformatf("src_ok%0d", i), {63'd0, src_ok[i]}, {63'd0, e_ok[i]});
        end
        chk("operands_valid", {63'd0, operands_valid}, {63'd0, e_ov});
        chk("stall_cnt", {32'd0, stall_cnt}, m_cnt);
        chk("stall_cnt_w4", {60'd0, stall_cnt_s}, 64'(m_cnt4));
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin cyc(); adv(); end
    endtask

    task automatic set_src(input int i, input bit en, input logic [4:0] a, input logic [63:0] rf);
        src_en[i] = en; src_addr[i*5 +: 5] = a; src_rf[i*XLEN +: XLEN] = rf;
    endtask

    task automatic set_fwd(input int k, input bit en, input logic [4:0] rd, input logic [63:0] d, input bit ok);
        fwd_rd_en[k] = en; fwd_rd[k*5 +: 5] = rd; fwd_data[k*XLEN +: XLEN] = d; fwd_data_ok[k] = ok;
    endtask

    task automatic idle();
        exe_valid = 1'b0; exe_ready = 1'b0; exe_flush = 1'b0;
        for (int i = 0; i < NS; i++) set_src(i, 1'b0, 5'd0, 64'h100 + 64'(i));
        for (int k = 0; k < NF; k++) set_fwd(k, 1'b0, 5'd0, 64'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        adv();
        step(1);
        cyc(); chk("reset_stall_cnt", {32'd0, stall_cnt}, 64'd0); adv();
        rst = 1'b0;

        // youngest stage wins over an older match
        exe_valid = 1'b1; exe_ready = 1'b1;
        set_src(1, 1'b1, 5'd5, 64'h111);
        set_fwd(0, 1'b1, 5'd5, 64'hA, 1'b1);
        set_fwd(1, 1'b1, 5'd5, 64'hB, 1'b1);
        cyc();
        chk("prio_out1", src_out[1*XLEN +: XLEN], 64'hA);
        chk("prio_ok1", {63'd0, src_ok[1]}, 64'd1);
        chk("prio_ov", {63'd0, operands_valid}, 64'd1);
        adv();

        // x0 never forwarded
        idle(); exe_valid = 1'b1; exe_ready = 1'b1;
        set_src(0, 1'b1, 5'd0, 64'h55);
        set_fwd(0, 1'b1, 5'd0, 64'hFF, 1'b1);
        cyc();
        chk("x0_out0", src_out[0 +: XLEN], 64'h55);
        chk("x0_ov", {63'd0, operands_valid}, 64'd1);
        adv();

        // youngest winner not ready: no fall-through, stall counts
        idle(); exe_valid = 1'b1;
        set_src(0, 1'b1, 5'd7, 64'h70);
        set_fwd(0, 1'b1, 5'd7, 64'h1, 1'b0);
        set_fwd(1, 1'b1, 5'd7, 64'h3, 1'b1);
        for (int j = 0; j < 3; j++) begin
            cyc();
            chk("stall_ok0", {63'd0, src_ok[0]}, 64'd0);
            chk("stall_ov", {63'd0, operands_valid}, 64'd0);
            chk("stall_cnt_inc", {32'd0, stall_cnt}, 64'(j));
            adv();
        end

        // capture from stage1 in one cycle, then hold against a changing network
        idle(); exe_valid = 1'b1;
        set_src(2, 1'b1, 5'd9, 64'h99);
        set_src(0, 1'b1, 5'd3, 64'h30);
        set_fwd(1, 1'b1, 5'd9, 64'h42, 1'b1);
        cyc(); chk("hold_c1", src_out[2*XLEN +: XLEN], 64'h42); adv();
        set_fwd(1, 1'b0, 5'd0, 64'd0, 1'b0);
        set_fwd(0, 1'b1, 5'd9, 64'h77, 1'b0);
        set_src(0, 1'b1, 5'd3, 64'h31);
        cyc();
        chk("hold_c2", src_out[2*XLEN +: XLEN], 64'h42);
        chk("hold_ok2", {63'd0, src_ok[2]}, 64'd1);
        chk("rf_not_held", src_out[0 +: XLEN], 64'h31);
        adv();
        cyc(); chk("hold_c3", src_out[2*XLEN +: XLEN], 64'h42); adv();
        exe_ready = 1'b1;
        step(1);
        exe_ready = 1'b0;
        set_fwd(0, 1'b0, 5'd0, 64'd0, 1'b0);
        cyc(); chk("ready_clears", src_out[2*XLEN +: XLEN], 64'h99); adv();

        // flush drops the hold
        set_fwd(1, 1'b1, 5'd9, 64'h42, 1'b1);
        step(1);
        set_fwd(1, 1'b0, 5'd0, 64'd0, 1'b0);
        exe_flush = 1'b1;
        cyc(); chk("flush_held", src_out[2*XLEN +: XLEN], 64'h42); adv();
        exe_flush = 1'b0;
        cyc(); chk("flush_clears", src_out[2*XLEN +: XLEN], 64'h99); adv();

        // reset mid-stall drops the hold and the count
        set_fwd(1, 1'b1, 5'd9, 64'h55, 1'b1);
        step(1);
        set_fwd(1, 1'b0, 5'd0, 64'd0, 1'b0);
        set_src(0, 1'b1, 5'd7, 64'h70);
        set_fwd(0, 1'b1, 5'd7, 64'h1, 1'b0);
        cyc(); chk("rst_held", src_out[2*XLEN +: XLEN], 64'h55); adv();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        cyc();
        chk("rst_clears", src_out[2*XLEN +: XLEN], 64'h99);
        chk("rst_cnt", {32'd0, stall_cnt}, 64'd0);
        adv();

        // long stall saturates the narrow counter
        step(19);
        cyc();
        chk("cnt_20", {32'd0, stall_cnt}, 64'd20);
        chk("cnt4_sat", {60'd0, stall_cnt_s}, 64'hF);
        adv();

        idle();
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bypass_net.md
BYPASS_NET -- requirements
Module: bypass_net

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 3, number of source operands (rs1, rs2, rs3).
REQ-003 SHALL have parameter NUM_FWD, default 2, number of forwarding stages; index 0 is youngest (MEM), NUM_FWD-1 oldest (WB).
REQ-004 SHALL have parameter CNT_W, default 32, width of the hazard stall counter.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 exe_valid  input  1  EXE stage holds a live instruction.
REQ-008 exe_ready  input  1  EXE stage retires its instruction this cycle.
REQ-009 exe_flush  input  1  EXE instruction squashed this cycle.
REQ-010 src_en  input  NUM_SRC  per-source read enable.
REQ-011 src_addr  input  NUM_SRC*5  per-source register index, source i at bits [5i+4:5i].
REQ-012 src_rf  input  NUM_SRC*XLEN  per-source register-file value from the ID/EXE register.
REQ-013 fwd_rd_en  input  NUM_FWD  stage k writes a destination register.
REQ-014 fwd_rd  input  NUM_FWD*5  stage k destination index.
REQ-015 fwd_data  input  NUM_FWD*XLEN  stage k result.
REQ-016 fwd_data_ok  input  NUM_FWD  stage k result is final (0 for an outstanding load or multi-cycle result).
REQ-017 src_out  output  NUM_SRC*XLEN  resolved operand values.
REQ-018 src_ok  output  NUM_SRC  per-source resolved flag.
REQ-019 operands_valid  output  1  AND of all src_ok bits.
REQ-020 stall_cnt  output  CNT_W  saturating count of operand-hazard stall cycles.

Function
REQ-021 Source i SHALL match stage k when src_en[i], fwd_rd_en[k], fwd_rd[k]==src_addr[i] and src_addr[i]!=0; x0 is never forwarded.
REQ-022 Among matching stages the lowest k SHALL win; there is no fall-through to an older stage when the winner's fwd_data_ok is 0.
REQ-023 src_ok[i] SHALL be 1 when hold_flag[i] is set, src_en[i] is 0, no stage matches, or the winning stage has fwd_data_ok=1; otherwise 0.
REQ-024 src_out[i] SHALL be hold_val[i] if hold_flag[i] is set, else the winner's fwd_data, else src_rf[i]; the path is combinational, zero latency.
REQ-025 While exe_valid=1, exe_ready=0 and exe_flush=0, each source whose hold_flag is clear, which has a winning stage and has src_ok=1 SHALL capture that stage's fwd_data into hold_val and set hold_flag on the next edge.
REQ-026 A set hold_flag SHALL be sticky, and the network SHALL be ignored for that source until clear.
REQ-027 A source resolved from src_rf SHALL NOT be captured.
REQ-028 exe_ready=1 or exe_flush=1 SHALL clear all hold_flag and hold_val on the next edge; if both coincide with a capture condition, clear wins.
REQ-029 stall_cnt SHALL increment by 1 each cycle with exe_valid=1, exe_flush=0 and operands_valid=0, and SHALL saturate at all-ones without wrapping.
REQ-030 src_en=0 sources SHALL drive src_rf[i] on src_out[i] and never stall.

Reset
REQ-031 On rst all hold_flag, hold_val and stall_cnt SHALL be 0 on the next edge, overriding every other update; outputs are then purely combinational from inputs.
REQ-032 rst asserted mid-stall SHALL discard held operands with no residual effect after deassertion.

Structure
REQ-033 XLEN default, register-index width (5) and the x0 index constant SHALL live in the shared common package.
REQ-034 One sub-module bypass_src (single-source match, priority, hold register) SHALL be instantiated NUM_SRC times via generate.
REQ-035 The stall counter and operands_valid reduction SHALL sit in the top level.

Verification
REQ-036 src1=x5 en, stage0 rd=x5 data=0xA ok=1, stage1 rd=x5 data=0xB -> src_out[1]=0xA, src_ok[1]=1.
REQ-037 src0=x7, stage0 rd=x7 ok=0, stage1 rd=x7 data=0x3 -> src_ok[0]=0, operands_valid=0, stall_cnt increments by 1 per cycle.
REQ-038 src0=x0, stage0 rd=x0 data=0xFF -> src_out[0]=src_rf[0], no stall.
REQ-039 exe_ready=0 for 3 cycles with stage1 supplying 0x42 for x9 in cycle 1 only -> src_out=0x42 in cycles 2-3; exe_ready=1 clears the hold.
REQ-040 Hold set, then exe_flush=1 and rst in separate runs -> hold_flag cleared next edge, src_out reverts to src_rf; stall_cnt=0 after rst.
REQ-041 CNT_W=4, 20 stall cycles -> stall_cnt holds 0xF.
